ife_dual_dispatch_collector: RTL and testbench
==============================================

Name: ife_dual_dispatch_collector

Overview:
- Initiator side of the dual-core block check. Accepts an instruction block ID, starts it on core 0 and core 1 in parallel, and captures each core's register-file result when that core signals done.
- Presents both captured results to the commit comparator and takes its ok/fail verdict in the same cycle.
- On fail, re-executes the block serially on core 0 only. Retires the final register state upstream.

Parameters:
- BLOCK_ID_WIDTH, 8, width of block identifier
- NUM_REGS, 32, architectural registers per result snapshot
- REG_WIDTH, 64, bits per register
- TIMEOUT_CYCLES, 1024, maximum wait cycles for core completion (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- blk_valid  in  1  upstream block request valid
- blk_ready  out  1  collector can accept a block
- blk_id  in  BLOCK_ID_WIDTH  requested block ID
- core_start  out  2  one-cycle start pulse; bit0 = core 0, bit1 = core 1
- core_block_id  out  BLOCK_ID_WIDTH  block ID driven to the cores
- core_serial  out  1  high while the serial re-execution is in flight
- core0_done  in  1  core 0 completion pulse
- core1_done  in  1  core 1 completion pulse
- core0_regs  in  REG_WIDTH x NUM_REGS  core 0 register snapshot, valid with core0_done
- core1_regs  in  REG_WIDTH x NUM_REGS  core 1 register snapshot, valid with core1_done
- cmt_valid  out  1  compare request to the commit comparator
- cmt_block_id  out  BLOCK_ID_WIDTH  block ID under compare
- cmt_result_0  out  REG_WIDTH x NUM_REGS  captured core 0 result
- cmt_result_1  out  REG_WIDTH x NUM_REGS  captured core 1 result
- cmt_ok  in  1  comparator verdict: match (combinational on cmt_valid)
- cmt_fail  in  1  comparator verdict: mismatch (combinational on cmt_valid)
- retire_valid  out  1  one-cycle retire pulse
- retire_id  out  BLOCK_ID_WIDTH  retired block ID
- retire_serial  out  1  block was re-executed serially
- retire_error  out  1  serial re-execution timed out
- retire_regs  out  REG_WIDTH x NUM_REGS  final register state (buf0)

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; all outputs 0; blk_ready = 1.
  - Done flags, timeout counter, ID register and both result buffers (buf0/buf1) cleared to 0.
  - Reset mid-operation abandons the block: no retire pulse, no start pulse.
- IDLE:
  - blk_ready = 1.
  - blk_valid & blk_ready → latch blk_id into id_q, go to DISPATCH.
  - blk_ready = 0 in every other state.
- DISPATCH (1 cycle): core_start = 2'b11, core_block_id = id_q. Clear done flags and timeout counter. Go to WAIT.
- WAIT:
  - Done pulses are sampled in WAIT only; done pulses in any other state are ignored.
  - coreN_done → coreN_regs captured into bufN; flagN set (sticky).
  - Both dones may arrive in the same cycle, in either order, or on different cycles.
  - Exit when both flags are set, or a pulse completes the pair → COMPARE on the next cycle.
  - Counter increments each WAIT cycle. If it reaches TIMEOUT_CYCLES−1 without both flags set → SERIAL_START (treated as fail).
- COMPARE:
  - cmt_valid = 1, cmt_block_id = id_q, cmt_result_0/1 = buf0/buf1.
  - cmt_ok → RETIRE with serial_q = 0.
  - cmt_fail → SERIAL_START.
  - Neither asserted → hold in COMPARE.
  - Both asserted → fail wins.
- SERIAL_START (1 cycle): core_start = 2'b01, core_serial = 1. Clear flag0 and counter. Go to SERIAL_WAIT.
- SERIAL_WAIT:
  - core_serial = 1; only core0_done is honoured.
  - core0_done → capture buf0, serial_q = 1 → RETIRE.
  - Timeout at TIMEOUT_CYCLES−1 → RETIRE with serial_q = 1, err_q = 1; buf0 holds stale data.
- RETIRE (1 cycle):
  - retire_valid = 1, retire_id = id_q, retire_serial = serial_q, retire_error = err_q, retire_regs = buf0.
  - Go to IDLE; clear err_q and serial_q.
- Outputs are registered-state decodes. cmt_result_* and retire_regs continuously reflect the buffers. Strobes are high only in the listed states.
- Latency, fastest pass path:
  - accept at cycle T
  - start at T+1
  - dones at T+2
  - compare at T+3
  - retire at T+4
  - blk_ready again at T+5
- Back-to-back blocks: minimum 5-cycle issue interval.

Test Plan:
- Match: block 0x12; both cores done at T+2 with identical regs (r5=0xDEAD); cmt_ok → core_start 2'b11 at T+1, cmt_valid at T+3, retire_valid at T+4 with id 0x12, serial=0, retire_regs[5]=0xDEAD.
- Mismatch: core1 r3=1 vs core0 r3=0; cmt_fail → core_start 2'b01 with core_serial=1 next cycle; core0_done with r3=7 → retire serial=1, error=0, retire_regs[3]=7.
- Skewed completion: core1_done at T+2, core0_done at T+9; stray core1_done repeated at T+5 → single compare at T+10; buf1 holds the T+5 snapshot.
- Timeout: TIMEOUT_CYCLES=8, core1 never done → serial start after 8 WAIT cycles; core0 also silent → retire with serial=1, error=1 after 8 SERIAL_WAIT cycles.
- Reset mid-WAIT: drop rst at T+2 → all outputs 0, blk_ready=1 after release, no retire pulse; a new block 0x34 then completes normally.
- Backpressure: blk_valid held high with IDs 1,2 → blk_ready low from DISPATCH through RETIRE; ID 2 accepted the cycle after retire of ID 1.

Source files
------------

// File: rtl/ife_dual_dispatch_collector_if.sv
// Bundle of the block-request, core, commit-comparator and retire signals of the
// dual-core dispatch collector; the collector takes the slave view.
interface ife_dual_dispatch_collector_if #(
    parameter int BLOCK_ID_WIDTH = 8,
    parameter int NUM_REGS       = 32,
    parameter int REG_WIDTH      = 64
);
    logic                                      blk_valid;
    logic                                      blk_ready;
    logic [BLOCK_ID_WIDTH-1:0]                 blk_id;
    logic [1:0]                                core_start;
    logic [BLOCK_ID_WIDTH-1:0]                 core_block_id;
    logic                                      core_serial;
    logic                                      core0_done;
    logic                                      core1_done;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0]        core0_regs;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0]        core1_regs;
    logic                                      cmt_valid;
    logic [BLOCK_ID_WIDTH-1:0]                 cmt_block_id;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0]        cmt_result_0;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0]        cmt_result_1;
    logic                                      cmt_ok;
    logic                                      cmt_fail;
    logic                                      retire_valid;
    logic [BLOCK_ID_WIDTH-1:0]                 retire_id;
    logic                                      retire_serial;
    logic                                      retire_error;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0]        retire_regs;

    modport slave (
        input  blk_valid, blk_id, core0_done, core1_done, core0_regs, core1_regs,
               cmt_ok, cmt_fail,
        output blk_ready, core_start, core_block_id, core_serial, cmt_valid,
               cmt_block_id, cmt_result_0, cmt_result_1, retire_valid, retire_id,
               retire_serial, retire_error, retire_regs
    );

    modport master (
        output blk_valid, blk_id, core0_done, core1_done, core0_regs, core1_regs,
               cmt_ok, cmt_fail,
        input  blk_ready, core_start, core_block_id, core_serial, cmt_valid,
               cmt_block_id, cmt_result_0, cmt_result_1, retire_valid, retire_id,
               retire_serial, retire_error, retire_regs
    );
endinterface

// File: rtl/ife_dual_dispatch_collector.sv
// Runs a block on both cores, collects both register snapshots for the commit
// comparator, and falls back to a serial core-0 re-run on mismatch or timeout.
module ife_dual_dispatch_collector #(
    parameter int BLOCK_ID_WIDTH = 8,
    parameter int NUM_REGS       = 32,
    parameter int REG_WIDTH      = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    ife_dual_dispatch_collector_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef logic [NUM_REGS-1:0][REG_WIDTH-1:0] snap_t;

    typedef enum logic [2:0] {
        S_IDLE, S_DISPATCH, S_WAIT, S_COMPARE, S_SERIAL_START, S_SERIAL_WAIT, S_RETIRE
    } state_t;

    state_t                    state_reg, state_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic [BLOCK_ID_WIDTH-1:0] id_reg, id_next;
    logic                      serial_reg, serial_next;
    logic                      err_reg, err_next;

    logic [1:0] done_in;
    logic [1:0] capture;
    logic [1:0] flag_clr;
    logic [1:0] flag_q;
    snap_t      regs_in [2];
    snap_t      buf_q   [2];
    logic       pair_done;
    logic       timeout_hit;

    assign done_in    = {bus.core1_done, bus.core0_done};
    assign regs_in[0] = bus.core0_regs;
    assign regs_in[1] = bus.core1_regs;

    // Core 1 is deaf during the serial re-run; both are deaf outside the wait states.
    always_comb begin
        capture  = 2'b00;
        flag_clr = 2'b00;
        case (state_reg)
            S_WAIT:         capture  = done_in;
            S_SERIAL_WAIT:  capture  = {1'b0, done_in[0]};
            S_DISPATCH:     flag_clr = 2'b11;
            S_SERIAL_START: flag_clr = 2'b01;
            default:        capture  = 2'b00;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_core
            snap_t buf_reg;
            logic  flag_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    buf_reg  <= '0;
                    flag_reg <= 1'b0;
                end else if (capture[gi]) begin
                    buf_reg  <= regs_in[gi];
                    flag_reg <= 1'b1;
                end else if (flag_clr[gi]) begin
                    flag_reg <= 1'b0;
                end
            end

            assign buf_q[gi]  = buf_reg;
            assign flag_q[gi] = flag_reg;
        end
    endgenerate

    // A pulse arriving this cycle may complete the pair before its flag is visible.
    assign pair_done   = (flag_q[0] | capture[0]) & (flag_q[1] | capture[1]);
    assign timeout_hit = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            id_reg     <= '0;
            serial_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            id_reg     <= id_next;
            serial_reg <= serial_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        id_next     = id_reg;
        serial_next = serial_reg;
        err_next    = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.blk_valid) begin
                    id_next    = bus.blk_id;
                    state_next = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                cnt_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (pair_done)        state_next = S_COMPARE;
                else if (timeout_hit) state_next = S_SERIAL_START;
                else                  cnt_next   = cnt_reg + 1'b1;
            end
            S_COMPARE: begin
                if (bus.cmt_fail) begin
                    state_next = S_SERIAL_START;
                end else if (bus.cmt_ok) begin
                    serial_next = 1'b0;
                    state_next  = S_RETIRE;
                end
            end
            S_SERIAL_START: begin
                cnt_next   = '0;
                state_next = S_SERIAL_WAIT;
            end
            S_SERIAL_WAIT: begin
                if (bus.core0_done) begin
                    serial_next = 1'b1;
                    state_next  = S_RETIRE;
                end else if (timeout_hit) begin
                    serial_next = 1'b1;
                    err_next    = 1'b1;
                    state_next  = S_RETIRE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_RETIRE: begin
                serial_next = 1'b0;
                err_next    = 1'b0;
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.blk_ready     = (state_reg == S_IDLE);
    assign bus.core_start    = (state_reg == S_DISPATCH)     ? 2'b11 :
                               (state_reg == S_SERIAL_START) ? 2'b01 : 2'b00;
    assign bus.core_block_id = id_reg;
    assign bus.core_serial   = (state_reg == S_SERIAL_START) || (state_reg == S_SERIAL_WAIT);
    assign bus.cmt_valid     = (state_reg == S_COMPARE);
    assign bus.cmt_block_id  = (state_reg == S_COMPARE) ? id_reg : '0;
    assign bus.cmt_result_0  = buf_q[0];
    assign bus.cmt_result_1  = buf_q[1];
    assign bus.retire_valid  = (state_reg == S_RETIRE);
    assign bus.retire_id     = (state_reg == S_RETIRE) ? id_reg : '0;
    assign bus.retire_serial = (state_reg == S_RETIRE) && serial_reg;
    assign bus.retire_error  = (state_reg == S_RETIRE) && err_reg;
    assign bus.retire_regs   = buf_q[0];
endmodule

// File: tb/tb_ife_dual_dispatch_collector.sv
// Bench for the dual-dispatch collector: directed scenarios with literal checks,
// then randomized core/comparator behaviour against a block-lifecycle model.
module tb_ife_dual_dispatch_collector;
    localparam int BW = 8;
    localparam int NR = 8;
    localparam int RW = 64;
    localparam int TO = 8;

    typedef logic [NR-1:0][RW-1:0] snap_t;
    typedef logic [511:0] cv_t;
    typedef enum {M_IDLE, M_START, M_COLLECT, M_JUDGE, M_RESTART, M_REDO, M_RETIRE} mphase_t;

    logic clk;
    logic rst;
    logic cmp_go;
    logic cmp_both;

    ife_dual_dispatch_collector_if #(.BLOCK_ID_WIDTH(BW), .NUM_REGS(NR), .REG_WIDTH(RW)) bus ();

    ife_dual_dispatch_collector #(
        .BLOCK_ID_WIDTH(BW), .NUM_REGS(NR), .REG_WIDTH(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Stand-in commit comparator: equality verdict, optionally stalled or double-asserted.
    assign bus.cmt_fail = bus.cmt_valid && cmp_go && (bus.cmt_result_0 != bus.cmt_result_1);
    assign bus.cmt_ok   = bus.cmt_valid && cmp_go &&
                          ((bus.cmt_result_0 == bus.cmt_result_1) || cmp_both);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    mphase_t         m_phase = M_IDLE;
    logic [BW-1:0]   m_id    = '0;
    snap_t           m_buf0  = '0;
    snap_t           m_buf1  = '0;
    bit              m_got0, m_got1, m_serial, m_err;
    int              m_waited;

    bit    resp_en = 1'b0;
    bit    acc     = 1'b0;
    int    cd0     = 0;
    int    cd1     = 0;
    snap_t pat0, pat1;

    task automatic chk(input string nm, input cv_t act, input cv_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic snap_t rand_snap();
        snap_t s;
        for (int i = 0; i < NR; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    function automatic int pick_delay();
        if ($urandom_range(0, 7) == 0) return 0;
        return int'($urandom_range(1, 10));
    endfunction

    // Per-cycle check of every DUT output against the lifecycle model, then advance it.
    task automatic model_check_and_step();
        logic [1:0] es;
        if (!rst) begin
            m_phase = M_IDLE; m_id = '0; m_buf0 = '0; m_buf1 = '0;
            m_serial = 1'b0; m_err = 1'b0; m_waited = 0;
        end
        es = (m_phase == M_START) ? 2'b11 : (m_phase == M_RESTART) ? 2'b01 : 2'b00;
        chk("blk_ready",    cv_t'(bus.blk_ready),    cv_t'(m_phase == M_IDLE));
        chk("core_start",   cv_t'(bus.core_start),   cv_t'(es));
        chk("core_serial",  cv_t'(bus.core_serial),  cv_t'(m_phase == M_RESTART || m_phase == M_REDO));
        chk("cmt_valid",    cv_t'(bus.cmt_valid),    cv_t'(m_phase == M_JUDGE));
        chk("retire_valid", cv_t'(bus.retire_valid), cv_t'(m_phase == M_RETIRE));
        chk("cmt_result_0", cv_t'(bus.cmt_result_0), cv_t'(m_buf0));
        chk("cmt_result_1", cv_t'(bus.cmt_result_1), cv_t'(m_buf1));
        chk("retire_regs",  cv_t'(bus.retire_regs),  cv_t'(m_buf0));
        if (es != 2'b00) chk("core_block_id", cv_t'(bus.core_block_id), cv_t'(m_id));
        if (m_phase == M_JUDGE) chk("cmt_block_id", cv_t'(bus.cmt_block_id), cv_t'(m_id));
        if (m_phase == M_RETIRE) begin
            chk("retire_id",     cv_t'(bus.retire_id),     cv_t'(m_id));
            chk("retire_serial", cv_t'(bus.retire_serial), cv_t'(m_serial));
            chk("retire_error",  cv_t'(bus.retire_error),  cv_t'(m_err));
        end
        if (!rst) return;
        case (m_phase)
            M_IDLE: if (bus.blk_valid) begin m_id = bus.blk_id; m_phase = M_START; end
            M_START: begin m_got0 = 0; m_got1 = 0; m_waited = 0; m_phase = M_COLLECT; end
            M_COLLECT: begin
                if (bus.core0_done) begin m_buf0 = bus.core0_regs; m_got0 = 1; end
                if (bus.core1_done) begin m_buf1 = bus.core1_regs; m_got1 = 1; end
                if (m_got0 && m_got1) m_phase = M_JUDGE;
                else begin
                    m_waited++;
                    if (m_waited == TO) m_phase = M_RESTART;
                end
            end
            M_JUDGE: begin
                if (bus.cmt_fail) m_phase = M_RESTART;
                else if (bus.cmt_ok) begin m_serial = 0; m_phase = M_RETIRE; end
            end
            M_RESTART: begin m_waited = 0; m_phase = M_REDO; end
            M_REDO: begin
                if (bus.core0_done) begin
                    m_buf0 = bus.core0_regs; m_serial = 1; m_phase = M_RETIRE;
                end else begin
                    m_waited++;
                    if (m_waited == TO) begin m_serial = 1; m_err = 1; m_phase = M_RETIRE; end
                end
            end
            M_RETIRE: begin m_serial = 0; m_err = 0; m_phase = M_IDLE; end
            default: m_phase = M_IDLE;
        endcase
    endtask

    task automatic respond();
        if (cd0 > 0) begin
            cd0--;
            if (cd0 == 0) begin bus.core0_done = 1'b1; bus.core0_regs = pat0; end
        end else if ($urandom_range(0, 24) == 0) begin
            bus.core0_done = 1'b1; bus.core0_regs = rand_snap();
        end
        if (cd1 > 0) begin
            cd1--;
            if (cd1 == 0) begin bus.core1_done = 1'b1; bus.core1_regs = pat1; end
        end else if ($urandom_range(0, 24) == 0) begin
            bus.core1_done = 1'b1; bus.core1_regs = rand_snap();
        end
        if (bus.core_start == 2'b11) begin
            pat0 = rand_snap();
            pat1 = pat0;
            if ($urandom_range(0, 3) == 0) pat1[$urandom_range(0, NR-1)] ^= 64'h1;
            cd0 = pick_delay();
            cd1 = pick_delay();
        end else if (bus.core_start == 2'b01) begin
            pat0 = rand_snap();
            cd0  = pick_delay();
            cd1  = 0;
        end
        cmp_go   = ($urandom_range(0, 2) != 0);
        cmp_both = ($urandom_range(0, 3) == 0);
        if (acc || !bus.blk_valid) begin
            bus.blk_valid = 1'($urandom_range(0, 1));
            bus.blk_id    = BW'($urandom);
        end
    endtask

    // One clock: model check at the falling edge, new stimulus just after the rising edge.
    task automatic tick();
        @(negedge clk);
        acc = bus.blk_valid && bus.blk_ready;
        model_check_and_step();
        @(posedge clk);
        #1;
        bus.core0_done = 1'b0;
        bus.core1_done = 1'b0;
        if (resp_en) respond();
    endtask

    // Fastest pass path starting from IDLE; literal expectations on every milestone.
    task automatic run_pass(input logic [BW-1:0] id, input snap_t s, input int r);
        bus.blk_valid = 1'b1; bus.blk_id = id;
        chk("pass_ready_T", cv_t'(bus.blk_ready), cv_t'(1));
        tick();
        bus.blk_valid = 1'b0;
        chk("pass_start", cv_t'(bus.core_start), cv_t'(2'b11));
        chk("pass_core_id", cv_t'(bus.core_block_id), cv_t'(id));
        tick();
        bus.core0_done = 1'b1; bus.core0_regs = s;
        bus.core1_done = 1'b1; bus.core1_regs = s;
        tick();
        chk("pass_cmt_valid", cv_t'(bus.cmt_valid), cv_t'(1));
        chk("pass_cmt_id", cv_t'(bus.cmt_block_id), cv_t'(id));
        tick();
        chk("pass_retire", cv_t'(bus.retire_valid), cv_t'(1));
        chk("pass_retire_id", cv_t'(bus.retire_id), cv_t'(id));
        chk("pass_serial", cv_t'(bus.retire_serial), cv_t'(0));
        chk("pass_reg", cv_t'(bus.retire_regs[r]), cv_t'(s[r]));
        tick();
        chk("pass_ready_T5", cv_t'(bus.blk_ready), cv_t'(1));
    endtask

    initial begin
        snap_t s0, s1, s2;
        rst = 1'b0; cmp_go = 1'b1; cmp_both = 1'b0;
        bus.blk_valid = 1'b0; bus.blk_id = '0;
        bus.core0_done = 1'b0; bus.core1_done = 1'b0;
        bus.core0_regs = '0; bus.core1_regs = '0;
        m_got0 = 0; m_got1 = 0; m_serial = 0; m_err = 0; m_waited = 0;
        pat0 = '0; pat1 = '0;

        tick();
        chk("reset_ready", cv_t'(bus.blk_ready), cv_t'(1));
        chk("reset_retire", cv_t'(bus.retire_valid), cv_t'(0));
        tick();
        rst = 1'b1;
        tick();

        // Match, block 0x12, r5 = 0xDEAD
        s0 = '0; s0[5] = 64'hDEAD;
        run_pass(8'h12, s0, 5);

        // Mismatch in r3, serial re-run returns r3 = 7
        s0 = '0; s1 = '0; s1[3] = 64'h1; s2 = '0; s2[3] = 64'h7;
        bus.blk_valid = 1'b1; bus.blk_id = 8'h21;
        tick(); bus.blk_valid = 1'b0;
        tick();
        bus.core0_done = 1'b1; bus.core0_regs = s0;
        bus.core1_done = 1'b1; bus.core1_regs = s1;
        tick(); chk("mm_cmt_valid", cv_t'(bus.cmt_valid), cv_t'(1));
        tick();
        chk("mm_serial_start", cv_t'(bus.core_start), cv_t'(2'b01));
        chk("mm_core_serial", cv_t'(bus.core_serial), cv_t'(1));
        tick();
        bus.core0_done = 1'b1; bus.core0_regs = s2;
        tick();
        chk("mm_retire", cv_t'(bus.retire_valid), cv_t'(1));
        chk("mm_serial", cv_t'(bus.retire_serial), cv_t'(1));
        chk("mm_error", cv_t'(bus.retire_error), cv_t'(0));
        chk("mm_r3", cv_t'(bus.retire_regs[3]), cv_t'(64'h7));
        tick();

        // Skewed completion with a repeated core1 pulse
        s0 = '0; s0[0] = 64'hA; s1 = '0; s1[0] = 64'hB;
        bus.blk_valid = 1'b1; bus.blk_id = 8'h5A;
        tick(); bus.blk_valid = 1'b0;
        tick(); bus.core1_done = 1'b1; bus.core1_regs = s0;
        repeat (3) tick();
        bus.core1_done = 1'b1; bus.core1_regs = s1;
        repeat (4) tick();
        bus.core0_done = 1'b1; bus.core0_regs = s1;
        chk("skew_no_cmt_T9", cv_t'(bus.cmt_valid), cv_t'(0));
        tick();
        chk("skew_cmt_T10", cv_t'(bus.cmt_valid), cv_t'(1));
        chk("skew_buf1", cv_t'(bus.cmt_result_1[0]), cv_t'(64'hB));
        tick();
        chk("skew_retire", cv_t'(bus.retire_valid), cv_t'(1));
        chk("skew_serial", cv_t'(bus.retire_serial), cv_t'(0));
        tick();

        // Timeout: core1 silent, then core0 silent during the serial re-run
        s0 = '0; s0[0] = 64'hC0FFEE;
        bus.blk_valid = 1'b1; bus.blk_id = 8'h77;
        tick(); bus.blk_valid = 1'b0;
        tick();
        tick(); bus.core0_done = 1'b1; bus.core0_regs = s0;
        repeat (6) tick();
        chk("to_no_start_T9", cv_t'(bus.core_start), cv_t'(2'b00));
        tick();
        chk("to_serial_start_T10", cv_t'(bus.core_start), cv_t'(2'b01));
        repeat (8) tick();
        chk("to_no_retire_T18", cv_t'(bus.retire_valid), cv_t'(0));
        tick();
        chk("to_retire_T19", cv_t'(bus.retire_valid), cv_t'(1));
        chk("to_serial", cv_t'(bus.retire_serial), cv_t'(1));
        chk("to_error", cv_t'(bus.retire_error), cv_t'(1));
        chk("to_stale_r0", cv_t'(bus.retire_regs[0]), cv_t'(64'hC0FFEE));
        tick();

        // Reset while waiting abandons the block
        bus.blk_valid = 1'b1; bus.blk_id = 8'h66;
        tick(); bus.blk_valid = 1'b0;
        tick();
        bus.core0_done = 1'b1; bus.core0_regs = rand_snap();
        rst = 1'b0;
        #1;
        chk("rst_ready", cv_t'(bus.blk_ready), cv_t'(1));
        chk("rst_start", cv_t'(bus.core_start), cv_t'(0));
        chk("rst_cmt_result_0", cv_t'(bus.cmt_result_0), cv_t'(0));
        tick(); tick();
        rst = 1'b1;
        repeat (4) begin
            tick();
            chk("rst_no_retire", cv_t'(bus.retire_valid), cv_t'(0));
        end
        s0 = rand_snap();
        run_pass(8'h34, s0, 2);

        // Backpressure: IDs 1 then 2 offered continuously
        s0 = rand_snap();
        bus.blk_valid = 1'b1; bus.blk_id = 8'h01;
        tick(); bus.blk_id = 8'h02;
        chk("bp_ready_T1", cv_t'(bus.blk_ready), cv_t'(0));
        tick();
        bus.core0_done = 1'b1; bus.core0_regs = s0;
        bus.core1_done = 1'b1; bus.core1_regs = s0;
        chk("bp_ready_T2", cv_t'(bus.blk_ready), cv_t'(0));
        tick(); chk("bp_ready_T3", cv_t'(bus.blk_ready), cv_t'(0));
        tick();
        chk("bp_ready_T4", cv_t'(bus.blk_ready), cv_t'(0));
        chk("bp_retire_id1", cv_t'(bus.retire_id), cv_t'(8'h01));
        tick(); chk("bp_ready_T5", cv_t'(bus.blk_ready), cv_t'(1));
        tick(); bus.blk_valid = 1'b0;
        chk("bp_start_id2", cv_t'(bus.core_start), cv_t'(2'b11));
        chk("bp_core_id2", cv_t'(bus.core_block_id), cv_t'(8'h02));
        tick();
        bus.core0_done = 1'b1; bus.core0_regs = s0;
        bus.core1_done = 1'b1; bus.core1_regs = s0;
        tick(); tick();
        chk("bp_retire_id2", cv_t'(bus.retire_id), cv_t'(8'h02));
        tick();

        // Randomized traffic, checked every cycle by the model
        resp_en = 1'b1;
        repeat (3000) tick();
        resp_en = 1'b0; bus.blk_valid = 1'b0; cmp_go = 1'b1; cmp_both = 1'b0;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
